// File: rtl/uart_rx_bit_sample.sv
// UART receive bit sequencer: synchronises rx, validates the start bit at
// mid-bit, samples DATA_BITS data bits LSB-first plus one stop bit at the
// bit centres using the shared OVS-times oversampling tick, and reports
// each frame with a one-cycle done or frame_error strobe.
module uart_rx_bit_sample #(
  parameter int DATA_BITS = 8,
  parameter int OVS       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_en,
  input  logic                 counter_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 done,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int SW = (OVS > 2) ? $clog2(OVS) : 1;
  localparam int NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // Tick count at the centre of the start bit and at the end of a full bit.
  localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  logic [1:0]           sync_q, sync_d;
  logic [1:0]           state_q, state_d;
  logic [SW-1:0]        s_q, s_d;
  logic [NW-1:0]        n_q, n_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 done_q, done_d;
  logic                 frame_error_q, frame_error_d;
  logic                 rx_s;

  // sync_q[1] is the second synchroniser stage; every decision uses it.
  assign rx_s = sync_q[1];

  // Next-state logic: frame sequencing, bit sampling and strobe generation.
  always_comb begin
    sync_d        = {sync_q[0], rx};
    state_d       = state_q;
    s_d           = s_q;
    n_d           = n_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    done_d        = 1'b0;
    frame_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        // rx_en only gates new frames; a frame in progress always completes.
        if (rx_en && !rx_s) begin
          s_d     = '0;
          state_d = START;
        end
      end
      START: begin
        if (counter_tick) begin
          if (s_q == S_HALF) begin
            if (!rx_s) begin
              s_d     = '0;
              n_d     = '0;
              state_d = DATA;
            end else begin
              // Line went high again before mid start bit: treat as a glitch.
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (counter_tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: begin // STOP
        if (counter_tick) begin
          if (s_q == S_LAST) begin
            state_d = IDLE;
            if (rx_s) begin
              rx_data_d = shift_q;
              done_d    = 1'b1;
            end else begin
              frame_error_d = 1'b1;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
    endcase
  end

  // State registers with synchronous reset; sync flops reset to line idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q        <= 2'b11;
      state_q       <= IDLE;
      s_q           <= '0;
      n_q           <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      done_q        <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      s_q           <= s_d;
      n_q           <= n_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      done_q        <= done_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign done        = done_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_bit_sample.sv
// Directed bench for uart_rx_bit_sample: table-driven single frames plus
// hand-written multi-cycle sequences (glitch, back-to-back, reset, rx_en drop).
module tb_uart_rx_bit_sample;

  localparam int BIT_CLKS = 64; // OVS=16 ticks, one tick every 4 clocks

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_en = 1'b1;
  logic       counter_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       done;
  logic       frame_error;
  logic       busy;

  int n_cmp = 0;
  int n_fail = 0;

  // Monitor state, written only by the monitor block.
  int         cyc = 0;
  int         done_cnt = 0;
  int         fe_cnt = 0;
  int         busy_cnt = 0;
  int         both_cnt = 0;
  int         last_done_cyc = 0;
  int         prev_done_cyc = 0;
  logic [7:0] last_done_data = 8'h00;
  logic [7:0] prev_done_data = 8'h00;

  uart_rx_bit_sample #(.DATA_BITS(8), .OVS(16)) dut (
    .clk(clk),
    .reset(reset),
    .rx_en(rx_en),
    .counter_tick(counter_tick),
    .rx(rx),
    .rx_data(rx_data),
    .done(done),
    .frame_error(frame_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Oversampling tick: one clock out of every four.
  initial begin
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      k = k + 1;
      counter_tick = ((k % 4) == 0);
    end
  end

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (done) begin
      done_cnt       <= done_cnt + 1;
      prev_done_cyc  <= last_done_cyc;
      last_done_cyc  <= cyc;
      prev_done_data <= last_done_data;
      last_done_data <= rx_data;
    end
    if (frame_error) fe_cnt <= fe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (done && frame_error) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  // Start bit, 8 data bits LSB-first, then a stop bit. A low stop bit is
  // held only part of a bit so the re-detected start resolves as a glitch.
  task automatic send_frame(input logic [7:0] d, input logic stop_hi, input int gap_bits);
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) hold(d[i], BIT_CLKS);
    if (stop_hi) hold(1'b1, BIT_CLKS);
    else         hold(1'b0, 48);
    hold(1'b1, gap_bits * BIT_CLKS);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_hi;
    logic       en;
    int         exp_done;
    int         exp_fe;
    logic [7:0] exp_rx;
  } vec_t;

  initial begin
    vec_t vecs[3];
    int d0, f0, b0, x0;

    vecs[0] = '{data: 8'hA5, stop_hi: 1'b1, en: 1'b1, exp_done: 1, exp_fe: 0, exp_rx: 8'hA5};
    vecs[1] = '{data: 8'h3C, stop_hi: 1'b0, en: 1'b1, exp_done: 0, exp_fe: 1, exp_rx: 8'hA5};
    vecs[2] = '{data: 8'h55, stop_hi: 1'b1, en: 1'b0, exp_done: 0, exp_fe: 0, exp_rx: 8'hA5};

    repeat (4) @(negedge clk);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_frame_error", int'(frame_error), 0);
    chk("reset_busy", int'(busy), 0);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    // Table-driven single frames.
    for (int v = 0; v < 3; v++) begin
      d0 = done_cnt; f0 = fe_cnt; b0 = busy_cnt;
      rx_en = vecs[v].en;
      send_frame(vecs[v].data, vecs[v].stop_hi, 3);
      rx_en = 1'b1;
      $display("frame %0d data=%02h stop=%0b en=%0b -> done=%0d fe=%0d rx_data=%02h busy=%0b",
               v, vecs[v].data, vecs[v].stop_hi, vecs[v].en,
               done_cnt - d0, fe_cnt - f0, rx_data, busy);
      chk($sformatf("v%0d_done", v), done_cnt - d0, vecs[v].exp_done);
      chk($sformatf("v%0d_fe", v), fe_cnt - f0, vecs[v].exp_fe);
      chk($sformatf("v%0d_rx_data", v), int'(rx_data), int'(vecs[v].exp_rx));
      chk($sformatf("v%0d_busy_end", v), int'(busy), 0);
      if (!vecs[v].en) chk("v_en0_busy_seen", b0 == busy_cnt ? 0 : 1, 0);
    end

    // Glitch: 3 ticks low, then high. START entered, then abandoned.
    d0 = done_cnt; f0 = fe_cnt; b0 = busy_cnt;
    hold(1'b0, 12);
    hold(1'b1, 2 * BIT_CLKS);
    $display("glitch -> busy_cycles=%0d done=%0d fe=%0d rx_data=%02h",
             busy_cnt - b0, done_cnt - d0, fe_cnt - f0, rx_data);
    chk("glitch_busy_seen", (busy_cnt - b0) > 0 ? 1 : 0, 1);
    chk("glitch_done", done_cnt - d0, 0);
    chk("glitch_fe", fe_cnt - f0, 0);
    chk("glitch_rx_data", int'(rx_data), 8'hA5);
    chk("glitch_busy_end", int'(busy), 0);

    // Back-to-back 0x00 then 0xFF, no idle gap between frames.
    d0 = done_cnt;
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 3);
    $display("b2b -> done=%0d spacing=%0d data0=%02h data1=%02h",
             done_cnt - d0, last_done_cyc - prev_done_cyc, prev_done_data, last_done_data);
    chk("b2b_done", done_cnt - d0, 2);
    chk("b2b_spacing", last_done_cyc - prev_done_cyc, 10 * BIT_CLKS);
    chk("b2b_data0", int'(prev_done_data), 8'h00);
    chk("b2b_data1", int'(last_done_data), 8'hFF);

    // Reset pulsed during data bit 4. Upper bits high so no restart follows.
    d0 = done_cnt; f0 = fe_cnt;
    fork
      send_frame(8'hF5, 1'b1, 3);
      begin
        repeat (BIT_CLKS + 4 * BIT_CLKS + 32) @(negedge clk);
        x0 = int'(busy);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("reset mid-frame -> busy_before=%0b busy=%0b rx_data=%02h done=%0b fe=%0b",
                 x0[0], busy, rx_data, done, frame_error);
        chk("rst_busy_before", x0, 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fe", int'(frame_error), 0);
      end
    join
    chk("rst_no_strobes", (done_cnt - d0) + (fe_cnt - f0), 0);

    // Clean frame after reset.
    d0 = done_cnt;
    send_frame(8'h81, 1'b1, 3);
    $display("frame 0x81 -> done=%0d rx_data=%02h", done_cnt - d0, rx_data);
    chk("f81_done", done_cnt - d0, 1);
    chk("f81_rx_data", int'(rx_data), 8'h81);

    // rx_en dropped after start detection: frame still completes.
    d0 = done_cnt; f0 = fe_cnt;
    fork
      send_frame(8'h55, 1'b1, 3);
      begin
        repeat (96) @(negedge clk);
        rx_en = 1'b0;
      end
    join
    $display("en drop 0x55 -> done=%0d fe=%0d rx_data=%02h", done_cnt - d0, fe_cnt - f0, rx_data);
    chk("endrop_done", done_cnt - d0, 1);
    chk("endrop_fe", fe_cnt - f0, 0);
    chk("endrop_rx_data", int'(rx_data), 8'h55);
    rx_en = 1'b1;

    chk("never_done_and_fe", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
